hazard_unit: RTL
================

# hazard_unit

Pipeline hazard controller sitting between the IF/ID register and the ID-stage control decoder. It produces the `o_bubble` qualifier that the decoder consumes. It also detects load-use hazards against the ID/EX stage, and squashes wrong-path slots after taken branches and jumps. When the decoder flags an unknown command, it halts the pipeline and holds it halted.

## Interface
- `BRANCH_FLUSH_SLOTS`, 2: cycles IF/ID is flushed after a taken branch (1..15).
- `STALL_CNT_W`, 16: width of the load-use stall counter.

- `i_clk`  in  1  clock, rising edge.
- `i_rst`  in  1  reset, synchronous, active-high.
- `i_ifid_rs`  in  5  rs field of the instruction in ID.
- `i_ifid_rt`  in  5  rt field of the instruction in ID.
- `i_ifid_uses_rt`  in  1  the instruction in ID reads rt (R-type, SW, BEQ, BNE).
- `i_idex_memRead`  in  1  the instruction in EX is a load.
- `i_idex_rt`  in  5  destination register of the load in EX.
- `i_jump`  in  1  decoder jump flag for the instruction in ID.
- `i_unknown_command`  in  1  decoder unknown-opcode flag for the instruction in ID.
- `i_branch_taken`  in  1  a branch in EX resolved taken this cycle.
- `o_bubble`  out  1  1 passes decoded controls to ID/EX; 0 zeroes all write, branch and jump controls.
- `o_pc_write`  out  1  PC update enable.
- `o_ifid_write`  out  1  IF/ID load enable.
- `o_ifid_flush`  out  1  IF/ID is loaded with a NOP.
- `o_idex_flush`  out  1  ID/EX is loaded with a NOP.
- `o_halt`  out  1  pipeline halted (sticky).
- `o_stall_cnt`  out  STALL_CNT_W  saturating count of load-use stall cycles.

## Operation
- **States:** RUN, FLUSH, HALT.
- **Internal counter:** `flush_cnt` is 4 bits.
- **Load-use condition `lu`:** `i_idex_memRead` is set, `i_idex_rt` is not 0, and either `i_idex_rt == i_ifid_rs` or (`i_ifid_uses_rt` is set and `i_idex_rt == i_ifid_rt`).
- **RUN:** evaluate these in priority order. Outputs are combinational from state and inputs.
  1. **`i_branch_taken`:**
     - Outputs: `o_pc_write`=1, `o_ifid_write`=1, `o_ifid_flush`=1, `o_idex_flush`=1, `o_bubble`=0.
     - If `BRANCH_FLUSH_SLOTS` > 1, go to FLUSH with `flush_cnt` = `BRANCH_FLUSH_SLOTS`-1; otherwise stay in RUN.
  2. **`lu`:**
     - Outputs: `o_pc_write`=0, `o_ifid_write`=0, `o_ifid_flush`=0, `o_idex_flush`=1, `o_bubble`=0.
     - Increment `o_stall_cnt` (saturating). Stay in RUN.
  3. **`i_unknown_command`:**
     - Outputs: `o_pc_write`=0, `o_ifid_write`=0, `o_idex_flush`=1, `o_bubble`=0. Go to HALT.
  4. **`i_jump`:**
     - Outputs: `o_bubble`=1, `o_pc_write`=1, `o_ifid_write`=1, `o_ifid_flush`=1, `o_idex_flush`=0.
  5. **Otherwise:** `o_bubble`=1, `o_pc_write`=1, `o_ifid_write`=1, both flushes 0.
- **FLUSH:**
  - Outputs: `o_pc_write`=1, `o_ifid_write`=1, `o_ifid_flush`=1, `o_idex_flush`=1, `o_bubble`=0.
  - `i_branch_taken`, `lu`, `i_jump` and `i_unknown_command` are ignored, because they belong to squashed slots.
  - Decrement `flush_cnt`. When `flush_cnt` == 1, return to RUN.
- **HALT:**
  - Outputs: `o_pc_write`=0, `o_ifid_write`=0, `o_bubble`=0, `o_ifid_flush`=0, `o_idex_flush`=1, `o_halt`=1.
  - All inputs are ignored. Only `i_rst` exits HALT.
- **`o_halt`:** registered; it is 1 exactly when state = HALT.
- **`o_stall_cnt`:** holds at all ones once saturated.

## Timing
- **While `i_rst`=1, outputs are forced:**
  - `o_pc_write`=0, `o_ifid_write`=0, `o_ifid_flush`=1, `o_idex_flush`=1, `o_bubble`=0.
  - `o_halt`=0, `o_stall_cnt`=0.
- **Registered values on the reset edge:** state becomes RUN and `flush_cnt` becomes 0.
- **Reset mid-operation:** reset taken during FLUSH or HALT returns to RUN on the next edge; no residual flush cycles remain.
- **Control latency:** all stall and flush controls are combinational, with 0-cycle latency relative to their causing input.
  - The state change takes effect at the next rising edge.
  - `o_halt` rises 1 cycle after the unknown-command cycle.
- **Load-use:** exactly one stall cycle per load. The next cycle the load is in MEM, `lu` deasserts naturally, and no extra state is used.
- **Taken branch:** total squashed cycles = `BRANCH_FLUSH_SLOTS`, counting the detection cycle.
- **Simultaneous events:**
  - Branch beats load-use, jump and unknown (the branch is the older instruction).
  - Load-use beats jump: the jump is retried next cycle, with `o_ifid_flush`=0 in the stall cycle.
  - Load-use beats unknown: halt occurs the following cycle if the unknown command is still in ID.

## Test plan
- **Load-use stall:** `i_idex_memRead`=1, `i_idex_rt`=5, `i_ifid_rs`=5 for one cycle. Expect `o_pc_write`=0, `o_ifid_write`=0, `o_bubble`=0, `o_idex_flush`=1 that cycle, and `o_stall_cnt` 0→1. With `i_idex_rt`=0 or `i_ifid_uses_rt`=0 on an rt match, expect no stall.
- **Taken branch, default parameter:** pulse `i_branch_taken` with `BRANCH_FLUSH_SLOTS`=2. Expect `o_ifid_flush`=1 for exactly 2 cycles and `o_bubble`=0 for both. A second `i_branch_taken` in cycle 2 has no effect, and RUN resumes in cycle 3.
- **Jump:** `i_jump`=1 alone. Expect `o_ifid_flush`=1, `o_bubble`=1, `o_idex_flush`=0 for 1 cycle. With `i_jump` and `lu` together, expect a stall with `o_ifid_flush`=0.
- **Unknown command:** `i_unknown_command`=1. Expect `o_halt`=1 from the next cycle. Then drive `i_branch_taken` and `lu` for 10 cycles: outputs stay at the halt values and `o_stall_cnt` is unchanged.
- **Reset mid-flush:** set `BRANCH_FLUSH_SLOTS`=4 and assert `i_rst` in the 2nd flush cycle. Expect the forced reset outputs that cycle, and RUN with `o_bubble`=1 the cycle after reset releases.
- **Counter saturation:** set `STALL_CNT_W`=2 and apply 5 load-use stalls. Expect `o_stall_cnt` = 1, 2, 3, 3, 3.

Source files
------------

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: load-use stalls, taken-branch/jump squashing, and
// a sticky halt on unknown opcodes. Stall/flush controls are combinational.
module hazard_unit #(
  parameter int unsigned BRANCH_FLUSH_SLOTS = 2,
  parameter int unsigned STALL_CNT_W        = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [4:0]             i_ifid_rs,
  input  logic [4:0]             i_ifid_rt,
  input  logic                   i_ifid_uses_rt,
  input  logic                   i_idex_memRead,
  input  logic [4:0]             i_idex_rt,
  input  logic                   i_jump,
  input  logic                   i_unknown_command,
  input  logic                   i_branch_taken,
  output logic                   o_bubble,
  output logic                   o_pc_write,
  output logic                   o_ifid_write,
  output logic                   o_ifid_flush,
  output logic                   o_idex_flush,
  output logic                   o_halt,
  output logic [STALL_CNT_W-1:0] o_stall_cnt
);

  typedef enum logic [1:0] {S_RUN, S_FLUSH, S_HALT} state_t;

  localparam logic [3:0] FLUSH_INIT = 4'(BRANCH_FLUSH_SLOTS - 1);

  state_t                 state;
  logic [3:0]             flush_cnt;
  logic [STALL_CNT_W-1:0] stall_cnt;
  logic                   lu;

  assign lu = i_idex_memRead && (i_idex_rt != 5'd0) &&
              ((i_idex_rt == i_ifid_rs) || (i_ifid_uses_rt && (i_idex_rt == i_ifid_rt)));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= S_RUN;
      flush_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      case (state)
        S_RUN: begin
          if (i_branch_taken) begin
            if (BRANCH_FLUSH_SLOTS > 1) begin
              state     <= S_FLUSH;
              flush_cnt <= FLUSH_INIT;
            end
          end else if (lu) begin
            if (stall_cnt != '1) stall_cnt <= stall_cnt + STALL_CNT_W'(1);
          end else if (i_unknown_command) begin
            state <= S_HALT;
          end
        end
        S_FLUSH: begin
          flush_cnt <= flush_cnt - 4'd1;
          if (flush_cnt == 4'd1) state <= S_RUN;
        end
        S_HALT: state <= S_HALT;
        default: state <= S_RUN;
      endcase
    end
  end

  // Reset overrides every control so nothing leaks into the pipe while it clears.
  always_comb begin
    o_bubble     = 1'b0;
    o_pc_write   = 1'b0;
    o_ifid_write = 1'b0;
    o_ifid_flush = 1'b0;
    o_idex_flush = 1'b1;
    o_halt       = 1'b0;
    o_stall_cnt  = stall_cnt;
    if (i_rst) begin
      o_ifid_flush = 1'b1;
      o_stall_cnt  = '0;
    end else begin
      case (state)
        S_RUN: begin
          if (i_branch_taken) begin
            o_pc_write   = 1'b1;
            o_ifid_write = 1'b1;
            o_ifid_flush = 1'b1;
          end else if (lu || i_unknown_command) begin
            o_idex_flush = 1'b1;
          end else begin
            o_bubble     = 1'b1;
            o_pc_write   = 1'b1;
            o_ifid_write = 1'b1;
            o_ifid_flush = i_jump;
            o_idex_flush = 1'b0;
          end
        end
        S_FLUSH: begin
          o_pc_write   = 1'b1;
          o_ifid_write = 1'b1;
          o_ifid_flush = 1'b1;
        end
        S_HALT: o_halt = 1'b1;
        default: ;
      endcase
    end
  end

endmodule
